// File: rtl/gray_sequence_checker_if.sv
// Sample/result bundle between a Gray-code source and gray_sequence_checker.
// The source drives sample_en and gray_in; the checker returns the decode and the lock and error status.
interface gray_sequence_checker_if #(
   parameter int N     = 4,
   parameter int ERR_W = 8
);
   logic             sample_en;
   logic [N-1:0]     gray_in;
   logic [N-1:0]     bin_out;
   logic             locked;
   logic             step_err;
   logic             wrap;
   logic [ERR_W-1:0] err_count;

   modport master (
      output sample_en, gray_in,
      input  bin_out, locked, step_err, wrap, err_count
   );

   modport slave (
      input  sample_en, gray_in,
      output bin_out, locked, step_err, wrap, err_count
   );
endinterface

// File: rtl/gray_sequence_checker.sv
// Decodes sampled Gray words and checks that they form a single-step up-counting sequence.
// It reports lock, wrap-around and illegal steps, and keeps a saturating count of illegal steps.
module gray_sequence_checker #(
   parameter int N        = 4,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input logic                   clk,
   input logic                   rst,
   gray_sequence_checker_if.slave bus
);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam logic [N-1:0]  ONE  = N'(1);
   localparam logic [N-1:0]  TOP  = {N{1'b1}};
   localparam logic [MW-1:0] GOAL = MW'(LOCK_CNT);

   typedef enum logic [1:0] {UNLOCKED, SYNC, LOCKED} state_t;

   function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
      logic [N-1:0] b;
      b[N-1] = g[N-1];
      for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      return (&v) ? v : v + ERR_W'(1);
   endfunction

   state_t           state;
   logic [MW-1:0]    match_cnt;
   logic [N-1:0]     prev_bin;
   logic [N-1:0]     bin_p1;
   logic             locked_p1;
   logic             step_err_p1;
   logic             wrap_p1;
   logic [ERR_W-1:0] err_count_p1;

   logic [N-1:0]  dec_p0;
   logic [N-1:0]  inc_val;
   logic [MW-1:0] match_nxt;
   logic          is_same;
   logic          is_inc;

   // Stage 0: decode and classify the incoming word against the reference
   always_comb begin
      dec_p0    = gray2bin(bus.gray_in);
      inc_val   = prev_bin + ONE;
      match_nxt = match_cnt + MW'(1);
      is_same   = (dec_p0 == prev_bin);
      is_inc    = (dec_p0 == inc_val);
   end

   // Stage 1: state update and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= UNLOCKED;
         match_cnt    <= '0;
         prev_bin     <= '0;
         bin_p1       <= '0;
         locked_p1    <= 1'b0;
         step_err_p1  <= 1'b0;
         wrap_p1      <= 1'b0;
         err_count_p1 <= '0;
      end else begin
         step_err_p1 <= 1'b0;
         wrap_p1     <= 1'b0;
         if (bus.sample_en) begin
            prev_bin <= dec_p0;
            bin_p1   <= dec_p0;
            if (state != UNLOCKED && is_inc && prev_bin == TOP)
               wrap_p1 <= 1'b1;
            case (state)
               UNLOCKED: begin
                  match_cnt <= '0;
                  state     <= SYNC;
               end
               SYNC: begin
                  if (is_inc) begin
                     match_cnt <= match_nxt;
                     if (match_nxt == GOAL) begin
                        state     <= LOCKED;
                        locked_p1 <= 1'b1;
                     end
                  end else if (!is_same) begin
                     match_cnt <= '0;
                  end
               end
               LOCKED: begin
                  if (!is_inc && !is_same) begin
                     step_err_p1  <= 1'b1;
                     err_count_p1 <= sat_inc(err_count_p1);
                     locked_p1    <= 1'b0;
                     match_cnt    <= '0;
                     state        <= SYNC;
                  end
               end
               default: state <= UNLOCKED;
            endcase
         end
      end
   end

   assign bus.bin_out   = bin_p1;
   assign bus.locked    = locked_p1;
   assign bus.step_err  = step_err_p1;
   assign bus.wrap      = wrap_p1;
   assign bus.err_count = err_count_p1;
endmodule

// File: tb/tb_gray_sequence_checker.sv
// Bench for gray_sequence_checker (N=4, LOCK_CNT=3, ERR_W=8) against a run-length reference model.
module tb_gray_sequence_checker;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   failed = 0;

   gray_sequence_checker_if #(.N(4), .ERR_W(8)) bus ();

   gray_sequence_checker #(.N(4), .LOCK_CNT(3), .ERR_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: tracks the last value, a count of consecutive +1 steps and a lock flag.
   bit       m_have;
   bit       m_locked;
   int       m_run;
   int       m_prev;
   int       m_bin;
   int       m_err;
   bit       e_step;
   bit       e_wrap;

   function automatic int g2b(input int g);
      int b = g;
      for (int s = 1; s < 4; s++) b = b ^ (g >> s);
      return b & 15;
   endfunction

   function automatic logic [3:0] b2g(input int b);
      int v = b & 15;
      return 4'(v ^ (v >> 1));
   endfunction

   task automatic model_reset();
      m_have = 0; m_locked = 0; m_run = 0; m_prev = 0; m_bin = 0; m_err = 0;
      e_step = 0; e_wrap = 0;
   endtask

   task automatic model_sample(input bit en, input int g);
      int b, diff;
      e_step = 0;
      e_wrap = 0;
      if (!en) return;
      b = g2b(g);
      diff = (b - m_prev + 16) % 16;
      if (!m_have) begin
         m_have = 1;
         m_run  = 0;
      end else begin
         if (diff == 1 && m_prev == 15) e_wrap = 1;
         if (m_locked) begin
            if (diff > 1) begin
               e_step = 1; m_locked = 0; m_run = 0;
               if (m_err < 255) m_err++;
            end
         end else if (diff == 1) begin
            m_run++;
            if (m_run >= 3) m_locked = 1;
         end else if (diff != 0) begin
            m_run = 0;
         end
      end
      m_prev = b;
      m_bin  = b;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".bin_out"},   int'(bus.bin_out),   m_bin);
      check({tag, ".locked"},    int'(bus.locked),    int'(m_locked));
      check({tag, ".step_err"},  int'(bus.step_err),  int'(e_step));
      check({tag, ".wrap"},      int'(bus.wrap),      int'(e_wrap));
      check({tag, ".err_count"}, int'(bus.err_count), m_err);
   endtask

   task automatic step(input string tag, input bit en, input logic [3:0] g);
      bus.sample_en = en;
      bus.gray_in   = g;
      @(posedge clk);
      #1;
      model_sample(en, int'(g));
      check_all(tag);
   endtask

   task automatic do_reset(input bit en, input logic [3:0] g);
      rst = 1'b1;
      bus.sample_en = en;
      bus.gray_in   = g;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.sample_en = 1'b0;
      model_reset();
      check_all("reset");
   endtask

   initial begin
      int base, k;
      bus.sample_en = 1'b0;
      bus.gray_in   = '0;
      model_reset();
      do_reset(1'b0, 4'b0000);

      // Lock-in from the documented Gray words
      step("lock0", 1'b1, 4'b0000);
      step("lock1", 1'b1, 4'b0001);
      step("lock2", 1'b1, 4'b0011);
      check("lock_not_yet", int'(bus.locked), 0);
      step("lock3", 1'b1, 4'b0010);
      check("lock_bin3", int'(bus.bin_out), 3);
      check("lock_up", int'(bus.locked), 1);

      // Count up to 13, then 14, 15 and wrap to 0
      for (int v = 4; v <= 13; v++) step("count", 1'b1, b2g(v));
      step("wrap14", 1'b1, 4'b1001);
      step("wrap15", 1'b1, 4'b1000);
      step("wrap0", 1'b1, 4'b0000);
      check("wrap_pulse", int'(bus.wrap), 1);
      check("wrap_bin", int'(bus.bin_out), 0);
      check("wrap_locked", int'(bus.locked), 1);
      step("wrap_idle", 1'b0, 4'b0000);
      check("wrap_one_cycle", int'(bus.wrap), 0);

      // Illegal step 6 -> 10 while locked
      for (int v = 1; v <= 4; v++) step("pre_bad", 1'b1, b2g(v));
      step("bad5", 1'b1, 4'b0111);
      step("bad6", 1'b1, 4'b0101);
      step("bad10", 1'b1, 4'b1111);
      check("bad_step_err", int'(bus.step_err), 1);
      check("bad_err_count", int'(bus.err_count), 1);
      check("bad_unlocked", int'(bus.locked), 0);
      step("bad_idle", 1'b0, 4'b1111);
      check("bad_one_cycle", int'(bus.step_err), 0);
      step("relock11", 1'b1, b2g(11));
      step("relock12", 1'b1, b2g(12));
      check("relock_not_yet", int'(bus.locked), 0);
      step("relock13", 1'b1, b2g(13));
      check("relock_up", int'(bus.locked), 1);

      // Hold: inputs toggle with sample_en low
      for (int i = 0; i < 20; i++) step("hold", 1'b0, 4'($urandom_range(0, 15)));
      check("hold_bin", int'(bus.bin_out), 13);
      check("hold_locked", int'(bus.locked), 1);

      // Randomised walk biased towards legal steps
      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 9);
         base = m_prev;
         if (k < 5)       base = base + 1;
         else if (k == 6) base = base + 15;
         else if (k == 7) base = $urandom_range(0, 15);
         step("random", ($urandom_range(0, 3) != 0), b2g(base));
      end

      // Saturation: drive repeated lock/error cycles until the counter tops out
      for (int i = 0; i < 400 && m_err < 255; i++) begin
         for (int j = 0; j < 4 && !m_locked; j++) step("sat_lock", 1'b1, b2g(m_prev + 1));
         step("sat_err", 1'b1, b2g(m_prev + $urandom_range(2, 14)));
      end
      check("sat_reached", int'(bus.err_count), 255);
      for (int j = 0; j < 4 && !m_locked; j++) step("sat_lock", 1'b1, b2g(m_prev + 1));
      check("sat_relocked", int'(bus.locked), 1);
      step("sat_over", 1'b1, b2g(m_prev + 7));
      check("sat_step_err", int'(bus.step_err), 1);
      check("sat_hold_255", int'(bus.err_count), 255);

      // Reset wins over a simultaneous BAD sample
      do_reset(1'b1, b2g(m_prev + 5));
      check("rst_err", int'(bus.err_count), 0);
      check("rst_locked", int'(bus.locked), 0);
      step("post_rst", 1'b1, b2g(9));
      check("post_rst_no_err", int'(bus.step_err), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #2000000;
      failed++;
      $display("FAIL timeout: bench did not complete");
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $fatal(1, "timeout");
   end
endmodule

// File: doc/gray_sequence_checker.md
GRAY_SEQUENCE_CHECKER -- requirements
Module: gray_sequence_checker

Interface
REQ-001 Parameter N, default 4: width of the Gray code word observed.
REQ-002 Parameter LOCK_CNT, default 3: consecutive valid increments required to declare lock.
REQ-003 Parameter ERR_W, default 8: width of the error counter.
REQ-004 Port clk  input  1: single system clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: reset, synchronous and active-high.
REQ-006 Port sample_en  input  1: when high, gray_in is sampled at this clock edge.
REQ-007 Port gray_in  input  N: Gray code word under observation, e.g. the counter LED bus.
REQ-008 Port bin_out  output  N: binary decode of the last accepted sample.
REQ-009 Port locked  output  1: high while the checker is tracking a valid up-counting sequence.
REQ-010 Port step_err  output  1: one-cycle pulse on an illegal step while locked.
REQ-011 Port wrap  output  1: one-cycle pulse on a valid increment from 2^N-1 to 0.
REQ-012 Port err_count  output  ERR_W: saturating count of step_err events.

Function
REQ-013 All outputs shall be registered; a sample accepted at edge k shall be reflected on the outputs after edge k, giving 1 cycle latency.
REQ-014 Decode: bin[N-1] = gray[N-1]; bin[i] = bin[i+1] XOR gray[i] for i from N-2 down to 0.
REQ-015 The checker shall hold the reference value prev_bin, updated to the new decode on every accepted sample.
REQ-016 Each accepted sample shall be classified against prev_bin:
  - SAME: equal;
  - INC: equals prev_bin+1 mod 2^N;
  - DEC: equals prev_bin-1 mod 2^N;
  - BAD: anything else.
REQ-017 FSM states: UNLOCKED, SYNC and LOCKED; match_cnt shall be width ceil(log2(LOCK_CNT+1)).
REQ-018 UNLOCKED, on sample: load prev_bin, set match_cnt=0, go to SYNC; no classification.
REQ-019 SYNC transitions:
  - INC: increment match_cnt; on reaching LOCK_CNT, go to LOCKED and assert locked.
  - SAME: no change.
  - DEC or BAD: set match_cnt=0 and stay in SYNC.
REQ-020 LOCKED transitions:
  - INC or SAME: stay in LOCKED.
  - DEC or BAD: pulse step_err, increment err_count, deassert locked, go to SYNC with match_cnt=0.
REQ-021 wrap shall pulse for an INC from 2^N-1 to 0 in SYNC or LOCKED; a wrap shall be a legal increment and never an error.
REQ-022 err_count shall saturate at 2^ERR_W-1; step_err shall still pulse when err_count is saturated.
REQ-023 When sample_en is low, state, prev_bin, bin_out and err_count shall hold, and step_err and wrap shall be 0.
REQ-024 step_err and wrap shall never be high for more than one cycle per accepted sample.
REQ-025 Errors in SYNC or UNLOCKED shall not touch step_err or err_count.

Reset
REQ-026 With rst high at an edge, the block shall set:
  - state UNLOCKED, match_cnt 0, prev_bin 0;
  - bin_out 0, locked 0, step_err 0, wrap 0, err_count 0.
REQ-027 rst shall take priority over a simultaneous sample_en; reset mid-sequence shall discard lock and error history.

Verification
REQ-028 The bench shall cover these scenarios, with N=4 and LOCK_CNT=3:
  - Lock-in: after reset, samples of gray 0000, 0001, 0011, 0010 -> bin_out 0,1,2,3; locked rises after the 4th sample; step_err stays 0.
  - Wrap: while locked, samples of gray 1001 (14) then 1000 (15) then 0000 (0) -> one-cycle wrap after the 0000 sample, bin_out 0, locked stays 1.
  - Illegal step: while locked, samples of gray 0111 (5), 0101 (6), then 1111 (10) -> step_err for exactly 1 cycle, err_count 1, locked 0; relock after 3 further increments.
  - Hold: sample_en low while gray_in toggles randomly for 20 cycles -> all outputs unchanged.
  - Saturation: with err_count preset to 255 by forcing errors -> one more error gives step_err pulse and err_count stays 255.
  - Reset priority: rst and sample_en high together with a BAD value -> next cycle all outputs at reset values.
